// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants and hex decoder shared by the 7-segment display mux.
package seg7_pkg;
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;
   localparam logic [6:0] GLYPH_0 = 7'b000_0001;
   localparam logic [6:0] GLYPH_1 = 7'b100_1111;
   localparam logic [6:0] GLYPH_2 = 7'b001_0010;
   localparam logic [6:0] GLYPH_3 = 7'b000_0110;
   localparam logic [6:0] GLYPH_4 = 7'b100_1100;
   localparam logic [6:0] GLYPH_5 = 7'b010_0100;
   localparam logic [6:0] GLYPH_6 = 7'b010_0000;
   localparam logic [6:0] GLYPH_7 = 7'b000_1111;
   localparam logic [6:0] GLYPH_8 = 7'b000_0000;
   localparam logic [6:0] GLYPH_9 = 7'b000_0100;
   localparam logic [6:0] GLYPH_A = 7'b000_1000;
   localparam logic [6:0] GLYPH_B = 7'b110_0000;
   localparam logic [6:0] GLYPH_C = 7'b011_0001;
   localparam logic [6:0] GLYPH_D = 7'b100_0010;
   localparam logic [6:0] GLYPH_E = 7'b011_0000;
   localparam logic [6:0] GLYPH_F = 7'b011_1000;

   // Bit 6 is segment a, bit 0 is segment g; 0 = segment on.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      case (nibble)
         4'h0: return GLYPH_0;
         4'h1: return GLYPH_1;
         4'h2: return GLYPH_2;
         4'h3: return GLYPH_3;
         4'h4: return GLYPH_4;
         4'h5: return GLYPH_5;
         4'h6: return GLYPH_6;
         4'h7: return GLYPH_7;
         4'h8: return GLYPH_8;
         4'h9: return GLYPH_9;
         4'hA: return GLYPH_A;
         4'hB: return GLYPH_B;
         4'hC: return GLYPH_C;
         4'hD: return GLYPH_D;
         4'hE: return GLYPH_E;
         default: return GLYPH_F;
      endcase
   endfunction
endpackage

// File: rtl/seg7_lz_mask.sv
// seg7_lz_mask: leading-zero suppress mask; digit 0 is never suppressed so zero still shows "0".
module seg7_lz_mask #(
   parameter int NUM_DIGITS = 4
) (
   input  logic [4*NUM_DIGITS-1:0] data_i,
   input  logic                    lz_blank_en_i,
   output logic [NUM_DIGITS-1:0]   suppress_o
);
   always_comb begin
      suppress_o = '0;
      for (int k = 1; k < NUM_DIGITS; k++)
         suppress_o[k] = lz_blank_en_i && ((data_i >> (4*k)) == '0);
   end
endmodule

// File: rtl/seg_7_display_mux.sv
// seg_7_display_mux: multiplexed common-anode hex display driver with dead-time,
// per-digit dp/blank, leading-zero blanking and PWM brightness.
module seg_7_display_mux
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int SLOT_CYCLES = 100_000,
   parameter int DEAD_CYCLES = 1_000,
   parameter int BRIGHT_W    = 3
) (
   input  logic                    clk_100MHz,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_blank_en,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [0:6]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   digit,
   output logic                    frame_tick
);
   localparam int TW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
   localparam int SW = $clog2(NUM_DIGITS);

   logic [TW-1:0]           slot_timer_q, slot_timer_d;
   logic [SW-1:0]           digit_sel_q, digit_sel_d;
   logic [BRIGHT_W-1:0]     pwm_cnt_q, brightness_q, brightness_d;
   logic [4*NUM_DIGITS-1:0] data_q, data_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d, suppress, digit_d;
   logic [6:0]              seg_d;
   logic                    dp_o_d, frame_d, slot_end, lit;
   logic [3:0]              nibble;

   seg7_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
      .data_i        (data_q),
      .lz_blank_en_i (lz_blank_en),
      .suppress_o    (suppress)
   );

   always_comb begin
      slot_end     = slot_timer_q == TW'(SLOT_CYCLES - 1);
      slot_timer_d = slot_end ? '0 : slot_timer_q + 1'b1;
      digit_sel_d  = !slot_end ? digit_sel_q :
                     digit_sel_q == SW'(NUM_DIGITS - 1) ? '0 : digit_sel_q + 1'b1;
      // Brightness only changes on a slot boundary so a duty change never chops a slot.
      brightness_d = slot_timer_q == '0 ? brightness : brightness_q;
      data_d       = load ? data_in : data_q;
      dp_d         = load ? dp_in : dp_q;
      blank_d      = load ? blank_in : blank_q;
      nibble       = 4'(data_q >> {digit_sel_q, 2'b00});
      lit          = slot_timer_q >= TW'(DEAD_CYCLES) && pwm_cnt_q <= brightness_q &&
                     !blank_q[digit_sel_q] && !suppress[digit_sel_q];
      digit_d      = lit ? ~(NUM_DIGITS'(1) << digit_sel_q) : '1;
      seg_d        = lit ? hex_to_seg(nibble) : SEG_BLANK;
      dp_o_d       = lit ? ~dp_q[digit_sel_q] : 1'b1;
      frame_d      = slot_end && digit_sel_q == SW'(NUM_DIGITS - 1);
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         slot_timer_q <= '0;
         digit_sel_q  <= '0;
         pwm_cnt_q    <= '0;
         brightness_q <= '0;
         data_q       <= '0;
         dp_q         <= '0;
         blank_q      <= '0;
         digit        <= '1;
         seg          <= SEG_BLANK;
         dp           <= 1'b1;
         frame_tick   <= 1'b0;
      end else begin
         slot_timer_q <= slot_timer_d;
         digit_sel_q  <= digit_sel_d;
         pwm_cnt_q    <= pwm_cnt_q + 1'b1;
         brightness_q <= brightness_d;
         data_q       <= data_d;
         dp_q         <= dp_d;
         blank_q      <= blank_d;
         digit        <= digit_d;
         seg          <= seg_d;
         dp           <= dp_o_d;
         frame_tick   <= frame_d;
      end
   end
endmodule

// File: tb/tb_seg_7_display_mux.sv
// tb_seg_7_display_mux: directed scenario bench for the multiplexed 7-segment driver.
module tb_seg_7_display_mux;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic        lz_blank_en = 1'b0;
   logic [1:0]  brightness = 2'd3;
   logic [0:6]  seg;
   logic        dp;
   logic [3:0]  digit;
   logic        frame_tick;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int lows [4];
   int dp_lows [4];
   logic [6:0] seen_seg [4];
   int ft_cnt, ft_first, dark_bad;
   int multi = 0;

   always #5 clk = ~clk;

   seg_7_display_mux #(
      .NUM_DIGITS(4), .SLOT_CYCLES(16), .DEAD_CYCLES(2), .BRIGHT_W(2)
   ) dut (
      .clk_100MHz (clk),
      .reset_n    (reset_n),
      .load       (load),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .lz_blank_en(lz_blank_en),
      .brightness (brightness),
      .seg        (seg),
      .dp         (dp),
      .digit      (digit),
      .frame_tick (frame_tick)
   );

   // Steps n cycles, sampling on the falling edge and tallying what the pins show.
   task automatic run_cycles(input int n);
      int z;
      for (int k = 0; k < 4; k++) begin
         lows[k] = 0;
         dp_lows[k] = 0;
         seen_seg[k] = 7'h7f;
      end
      ft_cnt = 0;
      ft_first = 0;
      dark_bad = 0;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (frame_tick === 1'b1) begin
            ft_cnt++;
            if (ft_first == 0) ft_first = cyc;
         end
         z = $countones(~digit);
         if (z == 0) begin
            if (seg !== 7'h7f || dp !== 1'b1) dark_bad++;
         end else if (z == 1) begin
            for (int k = 0; k < 4; k++)
               if (digit[k] === 1'b0) begin
                  lows[k]++;
                  seen_seg[k] = seg;
                  if (dp === 1'b0) dp_lows[k]++;
               end
         end else
            multi++;
      end
   endtask

   // Reset with load held so the shadow registers capture d on the first edge after release.
   task automatic do_reset(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                           input logic [1:0] br, input logic lz);
      @(negedge clk);
      reset_n = 1'b0;
      load = 1'b1;
      data_in = d;
      dp_in = p;
      blank_in = b;
      brightness = br;
      lz_blank_en = lz;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      cyc = 1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      load = 1'b1;
      data_in = 16'hFFFF;
      brightness = 2'd3;
      repeat (3) @(negedge clk);
      checks++; if (digit !== 4'hF) begin errors++; $display("FAIL reset_digit: got %b want 1111", digit); end
      checks++; if (seg !== 7'h7f) begin errors++; $display("FAIL reset_seg: got %b want 1111111", seg); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
      load = 1'b0;
      reset_n = 1'b1;
      cyc = 0;
      run_cycles(2);
      checks++; if (lows[0] !== 0 || dark_bad !== 0) begin errors++; $display("FAIL reset_dead_time: lows=%0d dark_bad=%0d want 0 0", lows[0], dark_bad); end
      run_cycles(1);
      checks++; if (digit !== 4'b1110 || seg !== 7'b0000001) begin errors++; $display("FAIL reset_first_lit: digit=%b seg=%b want 1110 0000001", digit, seg); end
   endtask

   task automatic test_scan;
      logic [6:0] exp_seg [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
      do_reset(16'h12AF, 4'b0000, 4'b0000, 2'd3, 1'b0);
      run_cycles(63);
      for (int k = 0; k < 4; k++) begin
         checks++; if (lows[k] !== 14) begin errors++; $display("FAIL scan_lows_d%0d: got %0d want 14", k, lows[k]); end
         checks++; if (seen_seg[k] !== exp_seg[k]) begin errors++; $display("FAIL scan_glyph_d%0d: got %b want %b", k, seen_seg[k], exp_seg[k]); end
      end
      checks++; if (ft_cnt !== 1 || ft_first !== 64) begin errors++; $display("FAIL scan_frame1: count=%0d at=%0d want 1 at 64", ft_cnt, ft_first); end
      checks++; if (dark_bad !== 0) begin errors++; $display("FAIL scan_dark_pins: got %0d want 0", dark_bad); end
      run_cycles(64);
      checks++; if (ft_cnt !== 1 || ft_first !== 128) begin errors++; $display("FAIL scan_frame2: count=%0d at=%0d want 1 at 128", ft_cnt, ft_first); end
   endtask

   task automatic test_lz_blank;
      do_reset(16'h0040, 4'b0000, 4'b0000, 2'd3, 1'b1);
      run_cycles(63);
      checks++; if (lows[3] !== 0 || lows[2] !== 0) begin errors++; $display("FAIL lz_upper_dark: d3=%0d d2=%0d want 0 0", lows[3], lows[2]); end
      checks++; if (lows[1] !== 14 || seen_seg[1] !== 7'b1001100) begin errors++; $display("FAIL lz_d1: lows=%0d seg=%b want 14 1001100", lows[1], seen_seg[1]); end
      checks++; if (lows[0] !== 14 || seen_seg[0] !== 7'b0000001) begin errors++; $display("FAIL lz_d0: lows=%0d seg=%b want 14 0000001", lows[0], seen_seg[0]); end
      do_reset(16'h0000, 4'b0000, 4'b0000, 2'd3, 1'b1);
      run_cycles(63);
      checks++; if (lows[1] !== 0 || lows[2] !== 0 || lows[3] !== 0) begin errors++; $display("FAIL lz_zero_upper: d1=%0d d2=%0d d3=%0d want 0 0 0", lows[1], lows[2], lows[3]); end
      checks++; if (lows[0] !== 14 || seen_seg[0] !== 7'b0000001) begin errors++; $display("FAIL lz_zero_d0: lows=%0d seg=%b want 14 0000001", lows[0], seen_seg[0]); end
   endtask

   task automatic test_brightness;
      do_reset(16'h12AF, 4'b0000, 4'b0000, 2'd0, 1'b0);
      run_cycles(15);
      checks++; if (lows[0] !== 3) begin errors++; $display("FAIL pwm_min_d0: got %0d want 3", lows[0]); end
      run_cycles(4);
      brightness = 2'd3;
      run_cycles(12);
      checks++; if (lows[1] !== 3) begin errors++; $display("FAIL pwm_change_midslot: got %0d want 3", lows[1]); end
      run_cycles(16);
      checks++; if (lows[2] !== 14) begin errors++; $display("FAIL pwm_next_slot: got %0d want 14", lows[2]); end
   endtask

   task automatic test_dp_blank;
      int exp_l [4] = '{14, 0, 14, 14};
      int exp_dp [4] = '{14, 0, 14, 0};
      do_reset(16'h12AF, 4'b0101, 4'b0010, 2'd3, 1'b0);
      run_cycles(63);
      for (int k = 0; k < 4; k++) begin
         checks++; if (lows[k] !== exp_l[k]) begin errors++; $display("FAIL blank_lows_d%0d: got %0d want %0d", k, lows[k], exp_l[k]); end
         checks++; if (dp_lows[k] !== exp_dp[k]) begin errors++; $display("FAIL dp_lows_d%0d: got %0d want %0d", k, dp_lows[k], exp_dp[k]); end
      end
      checks++; if (seen_seg[2] !== 7'b0010010 || seen_seg[3] !== 7'b1001111) begin errors++; $display("FAIL blank_others: d2=%b d3=%b want 0010010 1001111", seen_seg[2], seen_seg[3]); end
   endtask

   task automatic test_back_to_back;
      do_reset(16'h12AF, 4'b0000, 4'b0000, 2'd3, 1'b0);
      run_cycles(9);
      load = 1'b1;
      data_in = 16'h12A5;
      run_cycles(1);
      load = 1'b0;
      checks++; if (digit !== 4'b1110 || seg !== 7'b0111000) begin errors++; $display("FAIL midslot_before: digit=%b seg=%b want 1110 0111000", digit, seg); end
      run_cycles(1);
      checks++; if (digit !== 4'b1110 || seg !== 7'b0100100) begin errors++; $display("FAIL midslot_after: digit=%b seg=%b want 1110 0100100", digit, seg); end
      run_cycles(3);
      load = 1'b1;
      data_in = 16'h1275;
      run_cycles(1);
      load = 1'b0;
      run_cycles(2);
      checks++; if (lows[1] !== 0 || lows[0] !== 0) begin errors++; $display("FAIL wrap_dead: d0=%0d d1=%0d want 0 0", lows[0], lows[1]); end
      run_cycles(1);
      checks++; if (digit !== 4'b1101 || seg !== 7'b0001111) begin errors++; $display("FAIL wrap_load_glyph: digit=%b seg=%b want 1101 0001111", digit, seg); end
      run_cycles(64);
      checks++; if (multi !== 0 || dark_bad !== 0) begin errors++; $display("FAIL one_cold: multi=%0d dark_bad=%0d want 0 0", multi, dark_bad); end
   endtask

   task automatic test_async_reset;
      do_reset(16'h12AF, 4'b0001, 4'b0000, 2'd3, 1'b0);
      run_cycles(9);
      checks++; if (digit !== 4'b1110 || dp !== 1'b0) begin errors++; $display("FAIL arst_pre: digit=%b dp=%b want 1110 0", digit, dp); end
      #1 reset_n = 1'b0;
      #1;
      checks++; if (digit !== 4'hF || seg !== 7'h7f || dp !== 1'b1 || frame_tick !== 1'b0)
         begin errors++; $display("FAIL arst_immediate: digit=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0", digit, seg, dp, frame_tick); end
      load = 1'b1;
      data_in = 16'hFFFF;
      repeat (2) @(negedge clk);
      load = 1'b0;
      reset_n = 1'b1;
      cyc = 0;
      run_cycles(2);
      checks++; if (lows[0] !== 0 || dark_bad !== 0) begin errors++; $display("FAIL arst_dead: lows=%0d dark_bad=%0d want 0 0", lows[0], dark_bad); end
      run_cycles(1);
      checks++; if (digit !== 4'b1110 || seg !== 7'b0000001 || dp !== 1'b1)
         begin errors++; $display("FAIL arst_restart: digit=%b seg=%b dp=%b want 1110 0000001 1", digit, seg, dp); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_lz_blank();
      test_brightness();
      test_dp_blank();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
